// File: rtl/sam_seq_ctrl_if.sv
// Control/datapath bundle for the SAM sequencer.
// master: the sequencer. slave: the datapath and memory side.
interface sam_seq_ctrl_if #(
    parameter int DW   = 8,
    parameter int CNTW = 16
);
    logic            pause;
    logic            step;
    logic [1:0]      reg_select;
    logic [DW-1:0]   ireg_data;
    logic [DW-1:0]   pc_data;
    logic [DW-1:0]   acc_data;

    logic            ireg_en;
    logic            pc_en;
    logic            iar_en;
    logic            acc_en;
    logic            pc_add_sel;
    logic            pc_in_sel;
    logic [1:0]      acc_in_sel;
    logic [1:0]      alu_sel;
    logic            mem_en;
    logic            mem_rw;
    logic            ireg_buf;
    logic            pc_buf;
    logic            iar_buf;
    logic            acc_buf;
    logic            halted;
    logic [CNTW-1:0] instr_count;

    modport master (
        input  pause, step, reg_select, ireg_data, pc_data, acc_data,
        output ireg_en, pc_en, iar_en, acc_en, pc_add_sel, pc_in_sel, acc_in_sel,
               alu_sel, mem_en, mem_rw, ireg_buf, pc_buf, iar_buf, acc_buf,
               halted, instr_count
    );

    modport slave (
        output pause, step, reg_select, ireg_data, pc_data, acc_data,
        input  ireg_en, pc_en, iar_en, acc_en, pc_add_sel, pc_in_sel, acc_in_sel,
               alu_sel, mem_en, mem_rw, ireg_buf, pc_buf, iar_buf, acc_buf,
               halted, instr_count
    );
endinterface

// File: rtl/sam_seq_ctrl.sv
// SAM accumulator-machine sequencer: tick-counted FSM driving register
// enables, mux selects, ALU op and memory/bus-buffer controls.
// Optional feature macro: SAM_SEQ_STEP_EN (single-step out of PAUSE).
module sam_seq_ctrl #(
    parameter int DW   = 8,
    parameter int CNTW = 16
) (
    input  logic          clk,
    input  logic          rst,
    sam_seq_ctrl_if.master bus,
    output wire [DW-1:0]  disp
);
    typedef enum logic [4:0] {
        S_RST, S_PAUSE, S_FETCH, S_HALT, S_NEG, S_BR, S_BRZ, S_BRP, S_BRN,
        S_BRI, S_CLD, S_DLD, S_ILD, S_DST, S_IST, S_ADD, S_AND
    } state_t;

    state_t          state_reg, state_next;
    logic [3:0]      tick_reg;
    logic [CNTW-1:0] count_reg;
    logic            step_hold_reg, step_hold_next;
    logic            wrapup;

    logic ireg_en_reg, pc_en_reg, iar_en_reg, acc_en_reg, pc_add_sel_reg, pc_in_sel_reg;
    logic ireg_en_next, pc_en_next, iar_en_next, acc_en_next, pc_add_sel_next, pc_in_sel_next;
    logic [1:0] acc_in_sel_reg, acc_in_sel_next;
    logic [DW-1:0] disp_mux;

    wire [DW-1:0] acc = bus.acc_data;

    function automatic state_t decode(input logic [3:0] op, input logic [3:0] sub);
        case (op)
            4'h0:    return (sub == 4'h1) ? S_NEG : S_HALT;
            4'h1:    return S_BR;
            4'h2:    return S_BRZ;
            4'h3:    return S_BRP;
            4'h4:    return S_BRN;
            4'h5:    return S_BRI;
            4'h6:    return S_CLD;
            4'h7:    return S_DLD;
            4'h8:    return S_ILD;
            4'h9:    return S_DST;
            4'hA:    return S_IST;
            4'hB:    return S_ADD;
            4'hC:    return S_AND;
            default: return S_HALT;
        endcase
    endfunction

    // State, tick, retired counter and step-hold flag; reset overrides all.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= S_RST;
            tick_reg      <= 4'd0;
            count_reg     <= '0;
            step_hold_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            tick_reg      <= (state_next != state_reg) ? 4'd0 : tick_reg + 4'd1;
            step_hold_reg <= step_hold_next;
            if (wrapup)
                count_reg <= count_reg + CNTW'(1);
        end
    end

    // Next state: decode at FETCH t2, wrapup on each instruction's last tick.
    always_comb begin
        state_next     = state_reg;
        step_hold_next = step_hold_reg;
        wrapup         = 1'b0;
        case (state_reg)
            S_RST:   state_next = S_FETCH;
            S_PAUSE: begin
`ifdef SAM_SEQ_STEP_EN
                if (bus.pause && bus.step) begin
                    state_next     = S_FETCH;
                    step_hold_next = 1'b1;
                end else if (!bus.pause) begin
                    state_next = S_FETCH;
                end
`else
                if (!bus.pause)
                    state_next = S_FETCH;
`endif
            end
            S_FETCH: if (tick_reg == 4'd2)
                         state_next = decode(bus.ireg_data[DW-1 -: 4], bus.ireg_data[DW-5 -: 4]);
            S_HALT:  state_next = S_HALT;
            S_BR, S_BRZ, S_BRP, S_BRN, S_CLD, S_DLD: wrapup = (tick_reg == 4'd1);
            S_NEG, S_DST, S_ADD, S_AND:              wrapup = (tick_reg == 4'd2);
            S_BRI, S_IST:                            wrapup = (tick_reg == 4'd3);
            S_ILD:                                   wrapup = (tick_reg == 4'd4);
            default: state_next = S_HALT;
        endcase
        if (wrapup) begin
            state_next     = (bus.pause || step_hold_reg) ? S_PAUSE : S_FETCH;
            step_hold_next = 1'b0;
        end
    end

    // Outputs: bus controls valid this cycle, enables/selects staged for next cycle.
    always_comb begin
        bus.mem_en = 1'b0; bus.mem_rw = 1'b1;
        bus.ireg_buf = 1'b0; bus.pc_buf = 1'b0; bus.iar_buf = 1'b0; bus.acc_buf = 1'b0;
        bus.alu_sel = 2'b11; bus.halted = 1'b0;
        ireg_en_next = 1'b0; pc_en_next = 1'b0; iar_en_next = 1'b0; acc_en_next = 1'b0;
        pc_add_sel_next = 1'b0; pc_in_sel_next = 1'b0; acc_in_sel_next = 2'b00;
        case (state_reg)
            S_FETCH: begin
                pc_add_sel_next = 1'b1;
                if (tick_reg == 4'd0) begin
                    bus.mem_en = 1'b1; bus.pc_buf = 1'b1; ireg_en_next = 1'b1; pc_en_next = 1'b1;
                end
                if (tick_reg == 4'd2) bus.mem_en = 1'b1;
            end
            S_HALT: bus.halted = 1'b1;
            S_BR:  pc_en_next = (tick_reg == 4'd0);
            S_BRZ: pc_en_next = (tick_reg == 4'd0) && (acc == '0);
            S_BRP: pc_en_next = (tick_reg == 4'd0) && (acc != '0) && !acc[DW-1];
            S_BRN: pc_en_next = (tick_reg == 4'd0) && acc[DW-1];
            S_BRI: begin
                if (tick_reg == 4'd0) pc_en_next = 1'b1;
                if (tick_reg == 4'd2) begin
                    bus.mem_en = 1'b1; bus.pc_buf = 1'b1; pc_in_sel_next = 1'b1; pc_en_next = 1'b1;
                end
            end
            S_CLD: if (tick_reg == 4'd0) begin acc_in_sel_next = 2'b01; acc_en_next = 1'b1; end
            S_DLD: begin
                if (tick_reg == 4'd0) begin bus.mem_en = 1'b1; bus.ireg_buf = 1'b1; end
                if (tick_reg == 4'd1) begin acc_in_sel_next = 2'b01; acc_en_next = 1'b1; end
            end
            S_ILD: begin
                if (tick_reg == 4'd0) begin bus.mem_en = 1'b1; bus.ireg_buf = 1'b1; iar_en_next = 1'b1; end
                if (tick_reg == 4'd2) begin bus.mem_en = 1'b1; bus.iar_buf = 1'b1; end
                if (tick_reg == 4'd3) begin acc_in_sel_next = 2'b10; acc_en_next = 1'b1; end
            end
            S_DST: begin
                if (tick_reg == 4'd0) bus.mem_en = 1'b1;
                if (tick_reg == 4'd1) begin
                    bus.mem_en = 1'b1; bus.mem_rw = 1'b0; bus.ireg_buf = 1'b1; bus.acc_buf = 1'b1;
                end
            end
            S_IST: begin
                if (tick_reg == 4'd0) begin bus.mem_en = 1'b1; bus.ireg_buf = 1'b1; iar_en_next = 1'b1; end
                if (tick_reg == 4'd1) bus.mem_en = 1'b1;
                if (tick_reg == 4'd2) begin
                    bus.mem_en = 1'b1; bus.mem_rw = 1'b0; bus.iar_buf = 1'b1; bus.acc_buf = 1'b1;
                end
            end
            S_NEG, S_ADD, S_AND: begin
                bus.alu_sel = (state_reg == S_NEG) ? 2'b00 : (state_reg == S_ADD) ? 2'b01 : 2'b10;
                if (tick_reg == 4'd0 && state_reg != S_NEG) begin bus.mem_en = 1'b1; bus.ireg_buf = 1'b1; end
                if (tick_reg == 4'd1) begin acc_in_sel_next = 2'b11; acc_en_next = 1'b1; end
            end
            default: ;
        endcase
    end

    // Registered enables and mux selects; cleared by reset so nothing carries over.
    always_ff @(posedge clk) begin
        if (rst) begin
            ireg_en_reg <= 1'b0; pc_en_reg <= 1'b0; iar_en_reg <= 1'b0; acc_en_reg <= 1'b0;
            pc_add_sel_reg <= 1'b0; pc_in_sel_reg <= 1'b0; acc_in_sel_reg <= 2'b00;
        end else begin
            ireg_en_reg <= ireg_en_next; pc_en_reg <= pc_en_next; iar_en_reg <= iar_en_next;
            acc_en_reg <= acc_en_next; pc_add_sel_reg <= pc_add_sel_next;
            pc_in_sel_reg <= pc_in_sel_next; acc_in_sel_reg <= acc_in_sel_next;
        end
    end

    assign bus.ireg_en     = ireg_en_reg;
    assign bus.pc_en       = pc_en_reg;
    assign bus.iar_en      = iar_en_reg;
    assign bus.acc_en      = acc_en_reg;
    assign bus.pc_add_sel  = pc_add_sel_reg;
    assign bus.pc_in_sel   = pc_in_sel_reg;
    assign bus.acc_in_sel  = acc_in_sel_reg;
    assign bus.instr_count = count_reg;

    // Display mux; select 11 releases the display bus.
    always_comb begin
        case (bus.reg_select)
            2'b01:   disp_mux = bus.pc_data;
            2'b10:   disp_mux = bus.acc_data;
            default: disp_mux = bus.ireg_data;
        endcase
    end
    assign disp = (bus.reg_select == 2'b11) ? {DW{1'bz}} : disp_mux;

`ifndef SAM_SEQ_STEP_EN
    logic unused_step;
    assign unused_step = bus.step;
`endif

    generate
        if (DW > 8) begin : g_low_bits
            logic unused_low;
            assign unused_low = ^bus.ireg_data[DW-9:0];
        end
    endgenerate
endmodule

// File: doc/sam_seq_ctrl.md
# sam_seq_ctrl

Parametrised sequencer for the SAM accumulator datapath. It generalises the 8-bit controller to a DW-bit datapath and adds a retired-instruction counter, a halted flag and optional single-step execution. It drives register enables, mux selects, ALU op and memory/bus-buffer controls from a tick-counted FSM. It sits between the datapath (IReg, PC, IAR, Acc, ALU) and the shared memory bus.

## Interface
- DW, 8, datapath width; opcode = ireg_data[DW-1:DW-4], sub-op = ireg_data[DW-5:DW-8]; DW ≥ 8
- CNTW, 16, width of retired-instruction counter
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- pause  in  1  level; enter pause at next instruction boundary
- step  in  1  single-step pulse (SAM_SEQ_STEP_EN only)
- reg_select  in  2  display mux select
- ireg_data, pc_data, acc_data  in  DW  datapath register values
- ireg_en, pc_en, iar_en, acc_en  out  1  registered load enables
- pc_add_sel, pc_in_sel  out  1  registered PC mux selects
- acc_in_sel  out  2  registered Acc mux select
- alu_sel  out  2  comb: negate 00, add 01, and 10, else 11
- mem_en, mem_rw  out  1  comb memory enable; rw 1=read, 0=write
- ireg_buf, pc_buf, iar_buf, acc_buf  out  1  comb bus-buffer selects
- disp  out  DW  comb: 00 IReg, 01 PC, 10 Acc, 11 all-Z
- halted  out  1  comb, 1 while in HALT
- instr_count  out  CNTW  retired instructions

## Operation
- States: RST, PAUSE, FETCH, HALT, NEG, BR, BRZ, BRP, BRN, BRI, CLD, DLD, ILD, DST, IST, ADD, AND. A tick counter (4 bits) advances every cycle and is cleared on each state change.
- Registered outputs default to 0 every cycle. Comb outputs default to mem_rw=1 and everything else 0.
- Decode: op 0 with sub 1 → NEG; op 0 with any other sub → HALT; ops 1..C map to BR, BRZ, BRP, BRN, BRI, CLD, DLD, ILD, DST, IST, ADD, AND; D–F → HALT.
- FETCH:
  - pc_add_sel=1 on all ticks.
  - t0: mem_en, pc_buf, ireg_en, pc_en.
  - t2: mem_en; go to decoded state.
- BR: t0 pc_en; t1 wrapup.
- BRZ/BRP/BRN:
  - t0 pc_en if the condition holds: acc==0 / acc!=0 and acc[DW-1]==0 / acc[DW-1]==1.
  - t1 wrapup.
- BRI: t0 pc_en; t2 mem_en, pc_buf, pc_in_sel, pc_en; t3 wrapup.
- CLD: t0 acc_in_sel=01, acc_en; t1 wrapup.
- DLD: t0 mem_en, ireg_buf; t1 acc_in_sel=01, acc_en, wrapup.
- ILD: t0 mem_en, ireg_buf, iar_en; t2 mem_en, iar_buf; t3 acc_in_sel=10, acc_en; t4 wrapup.
- DST: t0 mem_en; t1 mem_en, mem_rw=0, ireg_buf, acc_buf; t2 wrapup.
- IST: t0 mem_en, ireg_buf, iar_en; t1 mem_en; t2 mem_en, mem_rw=0, iar_buf, acc_buf; t3 wrapup.
- ADD/AND: t0 mem_en, ireg_buf. NEG has no bus cycle. All three: t1 acc_in_sel=11, acc_en; t2 wrapup.
- wrapup:
  - instr_count += 1, wrapping modulo 2^CNTW.
  - Next state is PAUSE if pause (or step-mode hold), else FETCH; tick=0.
- PAUSE: leave to FETCH when pause==0.
- HALT: stays until rst; instr_count does not increment on entry.
- An undefined state encoding goes to HALT.

## Timing
- Reset, checked every cycle and overriding everything else:
  - state=RST, tick=0, instr_count=0, all registered outputs 0.
  - Next cycle the FSM goes to FETCH.
  - Reset in the middle of an instruction abandons it; no write is issued after the reset edge.
- Registered enables assert the cycle after the tick that commands them. Comb bus controls are valid in the same cycle as the state/tick.
- Instruction latency from FETCH t0 to the next FETCH t0 (no pause): BR/BRx/CLD 5, DLD 5, DST/NEG/ADD/AND 6, BRI/IST 7, ILD 8.
- pause is sampled only at wrapup and in PAUSE. Asserting it mid-instruction completes the instruction first.

## Configuration
- SAM_SEQ_STEP_EN defined:
  - While pause==1, a one-cycle step pulse in PAUSE moves to FETCH for exactly one instruction.
  - wrapup then returns to PAUSE regardless of pause's current value.
  - A step during execution is ignored.
- Undefined: step is ignored and PAUSE exits only on pause==0.

## Test plan
- rst high 2 cycles, release with memory[0]=0x61 (CLD 1) → FETCH next, acc_en pulse at cycle 5, instr_count=1.
- acc=0x00, BRZ → pc_en pulses. acc=0x80: BRP gives no pc_en, BRN pulses pc_en.
- IST with iar target 0x20 → mem_rw=0 only at t2 with iar_buf=acc_buf=1; 7-cycle latency.
- Opcode 0x00 → HALT, halted=1 for 100 cycles, instr_count frozen. Opcode 0x02 behaves the same.
- pause raised at ILD t1 → ILD completes (acc_en at t3+1), then PAUSE. Drop pause → FETCH next cycle.
- SAM_SEQ_STEP_EN with pause held, three step pulses → exactly 3 instructions, instr_count+3, back in PAUSE. rst during DST t1 → no write after reset.
